// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, byte width and header default for the UART transmit arbiter.
package uart_pkg;
   localparam int BYTE_W = 8;
   localparam logic [7:0] HDR_BASE_DEF = 8'hF0;
   typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DRAIN} arb_state_e;
   function automatic logic [2:0] oh2idx(input logic [7:0] oh);
      logic [2:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
      return r;
   endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker, first request at or after ptr_i with wrap.
module uart_rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic                 any_o
);
   logic [N-1:0] rot, low;
   // Rotate so ptr_i sits at bit 0, isolate the lowest request, rotate back.
   assign rot   = N'({req_i, req_i} >> ptr_i);
   assign low   = rot & -rot;
   assign gnt_o = N'(({low, low} << ptr_i) >> N);
   assign any_o = |req_i;
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: frame-level round-robin arbiter sharing one UART byte transmitter.
// Define UART_ARB_HDR_EN to prefix every frame with channel byte HDR_BASE + owner.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int          NUM_REQ      = 4,
   parameter logic [15:0] IDLE_TIMEOUT = 16'd0,
   parameter logic [7:0]  HDR_BASE     = HDR_BASE_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [BYTE_W-1:0]    uart_data,
   output logic                 uart_valid,
   input  logic                 uart_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 abort
);
   localparam int PW = $clog2(NUM_REQ);
   arb_state_e state_q;
   logic [NUM_REQ-1:0] grant_q, pick;
   logic [PW-1:0] rr_q, g_idx, rr_next;
   logic [BYTE_W-1:0] hold_q, g_data;
   logic [15:0] cnt_q;
   logic hold_full_q, abort_q, any, g_valid, g_last, cap, acc, stall, tmo;

   uart_rr_pick #(.N(NUM_REQ)) u_pick (
      .req_i (req_valid),
      .ptr_i (rr_q),
      .gnt_o (pick),
      .any_o (any)
   );

   assign g_idx     = PW'(oh2idx(8'(grant_q)));
   assign g_valid   = req_valid[g_idx];
   assign g_last    = req_last[g_idx];
   assign g_data    = req_data[8*g_idx +: 8];
   assign req_ready = (state_q == S_DATA && !hold_full_q) ? grant_q : '0;
   assign cap       = g_valid && state_q == S_DATA && !hold_full_q;
   assign acc       = hold_full_q && uart_ready;
   assign stall     = state_q == S_DATA && !hold_full_q && !g_valid;
   assign tmo       = (IDLE_TIMEOUT != 16'd0) && stall && (cnt_q + 16'd1 == IDLE_TIMEOUT);
   assign rr_next   = (int'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + PW'(1);
   assign uart_data  = hold_q;
   assign uart_valid = hold_full_q;
   assign grant      = grant_q;
   assign busy       = state_q != S_IDLE;
   assign abort      = abort_q;

`ifndef UART_ARB_HDR_EN
   logic unused_hdr;
   assign unused_hdr = ^HDR_BASE;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         rr_q        <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
         abort_q     <= 1'b0;
      end else begin
         abort_q <= 1'b0;
         if (acc) hold_full_q <= 1'b0;
         case (state_q)
            S_IDLE: if (any) begin
               grant_q <= pick;
`ifdef UART_ARB_HDR_EN
               hold_q      <= HDR_BASE + 8'(oh2idx(8'(pick)));
               hold_full_q <= 1'b1;
               state_q     <= S_HDR;
`else
               state_q     <= S_DATA;
`endif
            end
            S_HDR: if (acc) state_q <= S_DATA;
            S_DATA: if (cap) begin
               hold_q      <= g_data;
               hold_full_q <= 1'b1;
               cnt_q       <= '0;
               if (g_last) state_q <= S_DRAIN;
            end else if (tmo) begin
               abort_q <= 1'b1;
               grant_q <= '0;
               rr_q    <= rr_next;
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end else if (stall) cnt_q <= cnt_q + 16'd1;
            S_DRAIN: if (acc) begin
               grant_q <= '0;
               rr_q    <= rr_next;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
endmodule
